// File: rtl/lb_csr_tx.sv
// Local-bus CSR block: control/status/ID/scratch registers, W1C interrupt
// register with enable mask, and a software-filled TX FIFO drained by a
// valid/ready stream.
module lb_csr_tx #(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter int unsigned       READ_LAT   = 1,
    parameter logic [DATA_W-1:0] ID_VALUE   = 32'hC0DEBABE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   lb_waddr,
    input  logic [DATA_W-1:0]   lb_wdata,
    input  logic [DATA_W/8-1:0] lb_wstrb,
    input  logic                lb_wen,
    output logic                lb_wready,
    input  logic [ADDR_W-1:0]   lb_raddr,
    input  logic                lb_ren,
    output logic [DATA_W-1:0]   lb_rdata,
    output logic                lb_rvalid,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic                hw_event,
    output logic [3:0]          ctrl_mode,
    output logic                irq
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned WW     = ADDR_W - 2;

    localparam logic [WW-1:0] WCtrl    = WW'(0);
    localparam logic [WW-1:0] WStatus  = WW'(1);
    localparam logic [WW-1:0] WId      = WW'(2);
    localparam logic [WW-1:0] WIrq     = WW'(3);
    localparam logic [WW-1:0] WTxData  = WW'(4);
    localparam logic [WW-1:0] WScratch = WW'(5);
    localparam logic [WW-1:0] WIrqEn   = WW'(6);

    logic              wready_q;
    logic              en_q, en_d;
    logic [3:0]        mode_q, mode_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [2:0]        irq_en_q, irq_en_d;
    logic [2:0]        irq_q, irq_d;
    logic              irq_out_q, irq_out_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        rd_cnt_q, rd_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [WW-1:0]     wword, rword;
    logic              wr_acc, empty, full, pop, push_req, push_ok, ovf, unf;
    logic [DATA_W-1:0] rd_val;

    assign wword  = lb_waddr[ADDR_W-1:2];
    assign rword  = lb_raddr[ADDR_W-1:2];
    assign wr_acc = lb_wen & wready_q;
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(FIFO_DEPTH));

    // FIFO handshake: a pop frees a slot so a same-cycle push into a full FIFO succeeds
    always_comb begin
        tx_valid = en_q & ~empty;
        pop      = tx_valid & tx_ready;
        push_req = wr_acc && (wword == WTxData) && (&lb_wstrb);
        push_ok  = push_req & (~full | pop);
        ovf      = push_req & full & ~pop;
        unf      = tx_ready & empty & en_q;
    end

    // Register write decode with byte strobes; hardware IRQ sets win over W1C clears
    always_comb begin
        en_d      = en_q;
        mode_d    = mode_q;
        scratch_d = scratch_q;
        irq_en_d  = irq_en_q;
        irq_d     = irq_q;
        if (wr_acc) begin
            if (wword == WCtrl && lb_wstrb[0]) begin
                en_d   = lb_wdata[0];
                mode_d = lb_wdata[7:4];
            end
            if (wword == WScratch) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (lb_wstrb[b]) scratch_d[8*b +: 8] = lb_wdata[8*b +: 8];
                end
            end
            if (wword == WIrqEn && lb_wstrb[0]) irq_en_d = lb_wdata[2:0];
            if (wword == WIrq && lb_wstrb[0]) irq_d = irq_q & ~lb_wdata[2:0];
        end
        irq_d     = irq_d | {hw_event, unf, ovf};
        irq_out_d = |(irq_q & irq_en_q);
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            mem_d[wptr_q] = lb_wdata;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) rptr_d = rptr_q + AW'(1);
        count_d = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    // Read mux sampled at capture; write-only and unmapped addresses read 0
    always_comb begin
        rd_val = '0;
        case (rword)
            WCtrl: begin
                rd_val[0]   = en_q;
                rd_val[7:4] = mode_q;
            end
            WStatus: begin
                rd_val[0]      = empty;
                rd_val[1]      = full;
                rd_val[8 +: CW] = count_q;
            end
            WId:      rd_val = ID_VALUE;
            WIrq:     rd_val[2:0] = irq_q;
            WScratch: rd_val = scratch_q;
            WIrqEn:   rd_val[2:0] = irq_en_q;
            default:  ;
        endcase
    end

    // Read latency counter; requests arriving while one is outstanding are dropped
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        rvalid_d  = 1'b0;
        rd_data_d = rd_data_q;
        if (rd_cnt_q != 3'd0) begin
            rd_cnt_d = rd_cnt_q - 3'd1;
            rvalid_d = (rd_cnt_q == 3'd1);
        end else if (lb_ren) begin
            rd_cnt_d  = 3'(READ_LAT - 1);
            rvalid_d  = (READ_LAT == 1);
            rd_data_d = rd_val;
        end
    end

    // State registers; reset aborts any pending read and empties the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wready_q  <= 1'b0;
            en_q      <= 1'b0;
            mode_q    <= '0;
            scratch_q <= '0;
            irq_en_q  <= '0;
            irq_q     <= '0;
            irq_out_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_cnt_q  <= '0;
            rvalid_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wready_q  <= 1'b1;
            en_q      <= en_d;
            mode_q    <= mode_d;
            scratch_q <= scratch_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            irq_out_q <= irq_out_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_cnt_q  <= rd_cnt_d;
            rvalid_q  <= rvalid_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign lb_wready = wready_q;
    assign lb_rvalid = rvalid_q;
    assign lb_rdata  = rvalid_q ? rd_data_q : '0;
    assign tx_data   = mem_q[rptr_q];
    assign ctrl_mode = mode_q;
    assign irq       = irq_out_q;

endmodule

// File: tb/tb_lb_csr_tx.sv
// Directed bench for lb_csr_tx: one instance with READ_LAT=1 and one with
// READ_LAT=3 share all stimulus but have separate resets.
module tb_lb_csr_tx;
    logic        clk, rst1, rst3;
    logic [15:0] waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wen, ren, tx_ready, hw_event;

    logic        wready1, rvalid1, txv1, irq1;
    logic [31:0] rdata1, txd1;
    logic [3:0]  mode1;
    logic        wready3, rvalid3, txv3, irq3;
    logic [31:0] rdata3, txd3;
    logic [3:0]  mode3;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] d;
    int          lat, nv, first;
    logic [31:0] exp_q[$];

    lb_csr_tx #(.READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst1), .lb_waddr(waddr), .lb_wdata(wdata), .lb_wstrb(wstrb),
        .lb_wen(wen), .lb_wready(wready1), .lb_raddr(raddr), .lb_ren(ren),
        .lb_rdata(rdata1), .lb_rvalid(rvalid1), .tx_data(txd1), .tx_valid(txv1),
        .tx_ready(tx_ready), .hw_event(hw_event), .ctrl_mode(mode1), .irq(irq1)
    );

    lb_csr_tx #(.READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .lb_waddr(waddr), .lb_wdata(wdata), .lb_wstrb(wstrb),
        .lb_wen(wen), .lb_wready(wready3), .lb_raddr(raddr), .lb_ren(ren),
        .lb_rdata(rdata3), .lb_rvalid(rvalid3), .tx_data(txd3), .tx_valid(txv3),
        .tx_ready(tx_ready), .hw_event(hw_event), .ctrl_mode(mode3), .irq(irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] dat, input logic [3:0] s);
        @(negedge clk);
        waddr = a; wdata = dat; wstrb = s; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0; wstrb = 4'h0;
    endtask

    task automatic rd(input int sel, input logic [15:0] a, output logic [31:0] dat,
                      output int l);
        @(negedge clk);
        raddr = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        l = 1;
        while (!(sel == 3 ? rvalid3 : rvalid1) && l < 8) begin
            @(negedge clk);
            l++;
        end
        dat = (sel == 3) ? rdata3 : rdata1;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] v;
        int          l;
        rd(1, a, v, l);
        check({tag, " latency"}, l, 1);
        check(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b0; rst3 = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
        wen = 1'b0; ren = 1'b0; tx_ready = 1'b0; hw_event = 1'b0;
        repeat (2) @(negedge clk);
        check("rst wready", wready1, 0);
        check("rst rvalid", rvalid1, 0);
        check("rst rdata", rdata1, 0);
        check("rst tx_valid", txv1, 0);
        check("rst tx_data", txd1, 0);
        check("rst irq", irq1, 0);
        check("rst mode", mode1, 0);
        rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        check("wready after release", wready1, 1);

        // ID, unmapped, status
        rd_chk("id", 16'h0008, 32'hC0DEBABE);
        rd_chk("unmapped", 16'h0100, 32'h0);
        rd_chk("status reset", 16'h0004, 32'h1);

        // Scratch byte strobes
        wr(16'h0014, 32'hCAFEBABE, 4'b0110);
        rd_chk("scratch partial", 16'h0014, 32'h00FEBA00);
        wr(16'h0014, 32'hFFFFFFFF, 4'b1111);
        rd_chk("scratch full", 16'h0014, 32'hFFFFFFFF);

        // Enabled FIFO: three pushes then stream out
        wr(16'h0000, 32'h1, 4'hF);
        wr(16'h0010, 32'h11, 4'hF);
        wr(16'h0010, 32'h22, 4'hF);
        wr(16'h0010, 32'h33, 4'hF);
        rd_chk("status 3", 16'h0004, 32'h00000300);
        rd_chk("txdata reads 0", 16'h0010, 32'h0);
        rd_chk("status 3 again", 16'h0004, 32'h00000300);
        exp_q = '{32'h11, 32'h22, 32'h33};
        foreach (exp_q[i]) begin
            @(negedge clk);
            tx_ready = 1'b1;
            check("tx_valid", txv1, 1);
            check($sformatf("tx_data %0d", i), txd1, exp_q[i]);
        end
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_valid empty", txv1, 0);
        rd_chk("status drained", 16'h0004, 32'h1);
        wr(16'h0010, 32'hDEAD, 4'b0111);
        rd_chk("partial push dropped", 16'h0004, 32'h1);
        rd_chk("irq clean", 16'h000C, 32'h0);

        // EN=0, overfill, interrupt mask and W1C
        wr(16'h0000, 32'h50, 4'hF);
        check("ctrl_mode", mode1, 5);
        for (int i = 1; i <= 9; i++) wr(16'h0010, 32'(i), 4'hF);
        rd_chk("status full", 16'h0004, 32'h00000802);
        rd_chk("irq overflow", 16'h000C, 32'h1);
        check("tx_valid en0", txv1, 0);
        check("irq masked", irq1, 0);
        wr(16'h0018, 32'h1, 4'hF);
        @(negedge clk);
        check("irq asserted", irq1, 1);
        wr(16'h000C, 32'h1, 4'hF);
        @(negedge clk);
        check("irq cleared", irq1, 0);
        rd_chk("ctrl readback", 16'h0000, 32'h50);

        // Enable, then push and pop together while full
        wr(16'h0000, 32'h51, 4'hF);
        @(negedge clk);
        tx_ready = 1'b1; waddr = 16'h0010; wdata = 32'hAA; wstrb = 4'hF; wen = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0; wen = 1'b0; wstrb = 4'h0;
        rd_chk("status push+pop full", 16'h0004, 32'h00000802);
        rd_chk("no overflow on push+pop", 16'h000C, 32'h0);
        exp_q = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'hAA};
        foreach (exp_q[i]) begin
            @(negedge clk);
            tx_ready = 1'b1;
            check($sformatf("drain %0d", i), txd1, exp_q[i]);
        end
        @(negedge clk);
        check("tx_valid drained", txv1, 0);
        @(negedge clk);
        tx_ready = 1'b0;
        rd_chk("irq underflow", 16'h000C, 32'h2);
        check("underflow masked", irq1, 0);
        rd_chk("status after drain", 16'h0004, 32'h1);

        // hw_event set beats same-cycle W1C
        @(negedge clk);
        waddr = 16'h000C; wdata = 32'h6; wstrb = 4'hF; wen = 1'b1; hw_event = 1'b1;
        @(negedge clk);
        wen = 1'b0; wstrb = 4'h0; hw_event = 1'b0;
        rd_chk("hw_event wins", 16'h000C, 32'h4);
        wr(16'h000C, 32'h4, 4'hF);
        rd_chk("hw_event cleared", 16'h000C, 32'h0);

        // READ_LAT=3: a second ren while pending is ignored
        repeat (6) @(negedge clk);
        raddr = 16'h0008; ren = 1'b1;
        nv = 0; first = 0; d = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) ren = 1'b0;
            if (rvalid3) begin
                nv++;
                if (first == 0) begin
                    first = k;
                    d = rdata3;
                end
            end
        end
        check("lat3 rvalid count", nv, 1);
        check("lat3 latency", first, 3);
        check("lat3 data", d, 32'hC0DEBABE);

        // Reset in the middle of a READ_LAT=3 read
        wr(16'h0010, 32'h55, 4'hF);
        @(negedge clk);
        raddr = 16'h0004; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0; rst3 = 1'b0;
        #1;
        check("mid-reset rvalid", rvalid3, 0);
        check("mid-reset wready", wready3, 0);
        check("mid-reset tx_data", txd3, 0);
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid3) nv++;
        end
        check("aborted read silent", nv, 0);
        rd(3, 16'h0004, d, lat);
        check("post-reset latency", lat, 3);
        check("post-reset status", d, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
